calc_move_times: RTL and testbench

//  Converts per-axis motion parameters (step count, start/jerk speed, cruise speed,

---
 rtl/calc_move_times.sv | 174 +++++++++++++++++
 tb/tb_calc_move_times.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/calc_move_times.sv
// calc_move_times: per-axis accel/cruise/decel phase durations in clock cycles,
// computed serially through one shared 64/32 restoring divider.
module calc_move_times #(
  parameter int unsigned CLK_FREQ = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] params_x  [0:4],
  input  logic [31:0] params_y  [0:4],
  input  logic [31:0] params_z  [0:4],
  input  logic [31:0] params_e0 [0:4],
  input  logic [31:0] params_e1 [0:4],
  output logic [63:0] timing_x  [0:3],
  output logic [63:0] timing_y  [0:3],
  output logic [63:0] timing_z  [0:3],
  output logic [63:0] timing_e0 [0:3],
  output logic [63:0] timing_e1 [0:3],
  output logic        finish
);
  typedef enum logic [2:0] {IDLE, LOAD, PREP, DIV, DONE} state_t;
  localparam logic [63:0] FREQ = 64'(CLK_FREQ);
  state_t      state_q, state_d;
  logic [2:0]  ax_q, ax_d;
  logic        ph_q, ph_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, dvs_q, dvs_d;
  logic [63:0] quo_q, quo_d;
  logic        start_q, fin_q, fin_d, next_ax;
  logic [31:0] par_q [0:4][0:4];
  logic [31:0] par_d [0:4][0:4];
  logic [63:0] tim_q [0:4][0:3];
  logic [63:0] tim_d [0:4][0:3];
  logic [31:0] n, v0, v, a, na, rem_n;
  logic [32:0] na2, n33, run33, sh;
  logic [63:0] acc_num, const_num, quo_n;
  logic        ge;
  assign n  = par_q[ax_q][0];
  assign v0 = par_q[ax_q][1];
  assign v  = par_q[ax_q][2];
  assign a  = par_q[ax_q][3];
  assign na = par_q[ax_q][4];
  assign na2 = {na, 1'b0};
  assign n33 = {1'b0, n};
  assign run33 = (n33 > na2) ? n33 - na2 : '0;
  assign acc_num = {32'd0, v - v0} * FREQ;
  assign const_num = {31'd0, run33} * FREQ;
  // one restoring step: shift in next dividend bit, subtract if it fits
  assign sh = {rem_q, quo_q[63]};
  assign ge = sh >= {1'b0, dvs_q};
  assign rem_n = ge ? 32'(sh - {1'b0, dvs_q}) : sh[31:0];
  assign quo_n = {quo_q[62:0], ge};
  always_comb begin
    state_d = state_q;
    ax_d = ax_q;
    ph_d = ph_q;
    cnt_d = cnt_q;
    rem_d = rem_q;
    quo_d = quo_q;
    dvs_d = dvs_q;
    par_d = par_q;
    tim_d = tim_q;
    fin_d = fin_q;
    next_ax = 1'b0;
    case (state_q)
      IDLE: if (start && !start_q) begin
        par_d[0] = params_x;
        par_d[1] = params_y;
        par_d[2] = params_z;
        par_d[3] = params_e0;
        par_d[4] = params_e1;
        fin_d = 1'b0;
        state_d = LOAD;
      end
      LOAD: begin
        tim_d = '{default: '0};
        ax_d = '0;
        ph_d = 1'b0;
        state_d = PREP;
      end
      PREP: if (n == 0) begin
        tim_d[ax_q] = '{default: '0};
        next_ax = 1'b1;
      end else if (!ph_q) begin
        if (a == 0 || v <= v0) begin
          tim_d[ax_q][0] = '0;
          tim_d[ax_q][2] = '0;
          ph_d = 1'b1;
        end else begin
          quo_d = acc_num;
          rem_d = '0;
          dvs_d = a;
          cnt_d = '0;
          state_d = DIV;
        end
      end else if (v == 0) begin
        tim_d[ax_q][1] = '0;
        tim_d[ax_q][3] = tim_q[ax_q][0] + tim_q[ax_q][2];
        next_ax = 1'b1;
      end else begin
        quo_d = const_num;
        rem_d = '0;
        dvs_d = v;
        cnt_d = '0;
        state_d = DIV;
      end
      DIV: begin
        quo_d = quo_n;
        rem_d = rem_n;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          if (!ph_q) begin
            tim_d[ax_q][0] = quo_n;
            tim_d[ax_q][2] = quo_n;
            ph_d = 1'b1;
            state_d = PREP;
          end else begin
            tim_d[ax_q][1] = quo_n;
            tim_d[ax_q][3] = tim_q[ax_q][0] + quo_n + tim_q[ax_q][2];
            next_ax = 1'b1;
          end
        end
      end
      DONE: begin
        fin_d = start;
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (next_ax) begin
      if (ax_q == 3'd4) begin
        state_d = DONE;
        fin_d = start;
      end else begin
        ax_d = ax_q + 3'd1;
        ph_d = 1'b0;
        state_d = PREP;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ax_q <= '0;
      ph_q <= 1'b0;
      cnt_q <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      par_q <= '{default: '0};
      tim_q <= '{default: '0};
      fin_q <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      quo_q <= quo_d;
      dvs_q <= dvs_d;
      par_q <= par_d;
      tim_q <= tim_d;
      fin_q <= fin_d;
      start_q <= start;
    end
  end
  assign timing_x = tim_q[0];
  assign timing_y = tim_q[1];
  assign timing_z = tim_q[2];
  assign timing_e0 = tim_q[3];
  assign timing_e1 = tim_q[4];
  assign finish = fin_q;
endmodule

// File: tb/tb_calc_move_times.sv
// tb_calc_move_times: table vectors, randomized runs against an arithmetic model,
// and hand sequences for reset abort and start handshake corners.
module tb_calc_move_times;
  logic clk = 0, reset = 0, start = 0, finish;
  logic [31:0] px [0:4], py [0:4], pz [0:4], pe0 [0:4], pe1 [0:4];
  logic [63:0] tx [0:3], ty [0:3], tz [0:3], te0 [0:3], te1 [0:3];
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  calc_move_times dut (
    .clk(clk), .reset(reset), .start(start),
    .params_x(px), .params_y(py), .params_z(pz), .params_e0(pe0), .params_e1(pe1),
    .timing_x(tx), .timing_y(ty), .timing_z(tz), .timing_e0(te0), .timing_e1(te1),
    .finish(finish)
  );
  typedef struct packed {
    logic [31:0] n, v0, v, acc, na;
    logic [63:0] ta, tc, td, tt;
  } vec_t;
  typedef logic [3:0][63:0] t4_t;
  vec_t tbl [0:6];
  t4_t exp_t [0:4];
  function automatic t4_t model(logic [31:0] n, v0, v, a, na);
    t4_t r;
    logic [63:0] f, run;
    f = 64'd50_000_000;
    r = '0;
    if (n != 0) begin
      r[0] = (a == 0 || v <= v0) ? 64'd0 : (64'(v - v0) * f) / 64'(a);
      run = (64'(n) > 64'(na) * 2) ? 64'(n) - 64'(na) * 2 : 64'd0;
      r[1] = (v == 0) ? 64'd0 : (run * f) / 64'(v);
      r[2] = r[0];
      r[3] = r[0] + r[1] + r[2];
    end
    return r;
  endfunction
  task automatic set_axis(int ax, logic [31:0] n, v0, v, a, na);
    case (ax)
      0: px = '{n, v0, v, a, na};
      1: py = '{n, v0, v, a, na};
      2: pz = '{n, v0, v, a, na};
      3: pe0 = '{n, v0, v, a, na};
      default: pe1 = '{n, v0, v, a, na};
    endcase
  endtask
  function automatic logic [63:0] get(int ax, int i);
    case (ax)
      0: return tx[i];
      1: return ty[i];
      2: return tz[i];
      3: return te0[i];
      default: return te1[i];
    endcase
  endfunction
  task automatic chk(string name, logic [63:0] act, logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask
  task automatic launch();
    int cyc = 0;
    start = 1;
    while (!finish && cyc < 800) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("latency", 64'(finish && cyc <= 700), 64'd1);
  endtask
  task automatic release_start();
    start = 0;
    @(posedge clk); #1;
    chk("finish_drop", 64'(finish), 64'd0);
    @(posedge clk); #1;
  endtask
  task automatic check_all(string tag);
    for (int ax = 0; ax < 5; ax++)
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_ax%0d_t%0d", tag, ax, i), get(ax, i), exp_t[ax][i]);
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    tbl[0] = '{4000, 1000, 5000, 10000, 1200, 20_000_000, 16_000_000, 20_000_000, 56_000_000};
    tbl[1] = '{1000, 2000, 2000, 0, 0, 0, 25_000_000, 0, 25_000_000};
    tbl[2] = '{100, 1000, 2000, 10000, 80, 5_000_000, 0, 5_000_000, 10_000_000};
    tbl[3] = '{50, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[4] = '{200, 0, 100, 0, 100, 0, 0, 0, 0};
    tbl[5] = '{10, 500, 400, 100, 0, 0, 1_250_000, 0, 1_250_000};
    tbl[6] = '{7, 0, 3, 0, 0, 0, 116_666_666, 0, 116_666_666};
    for (int ax = 0; ax < 5; ax++) set_axis(ax, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_finish", 64'(finish), 64'd0);
    chk("rst_tx3", tx[3], 64'd0);
    reset = 1;
    @(posedge clk); #1;
    for (int k = 0; k < 7; k++) begin
      set_axis(0, tbl[k].n, tbl[k].v0, tbl[k].v, tbl[k].acc, tbl[k].na);
      for (int ax = 1; ax < 5; ax++) set_axis(ax, 0, 1, 9000, 5, 0);
      exp_t[0] = {tbl[k].tt, tbl[k].td, tbl[k].tc, tbl[k].ta};
      for (int ax = 1; ax < 5; ax++) exp_t[ax] = '0;
      launch();
      check_all($sformatf("tbl%0d", k));
      release_start();
    end
    for (int it = 0; it < 8; it++) begin
      for (int ax = 0; ax < 5; ax++) begin
        logic [31:0] n, v0, v, a, na;
        if (it == 0) begin
          n = $urandom; v0 = $urandom; v = $urandom; a = $urandom; na = $urandom_range(0, 3000);
        end else begin
          n = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 20000);
          v0 = $urandom_range(0, 3000);
          v = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(0, 9000);
          a = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(1, 200000);
          na = $urandom_range(0, 12000);
        end
        set_axis(ax, n, v0, v, a, na);
        exp_t[ax] = model(n, v0, v, a, na);
      end
      launch();
      check_all($sformatf("rnd%0d", it));
      release_start();
    end
    set_axis(0, 4000, 1000, 5000, 10000, 1200);
    for (int ax = 1; ax < 5; ax++) set_axis(ax, 0, 0, 0, 0, 0);
    start = 1;
    repeat (100) @(posedge clk);
    #1;
    chk("pre_abort_tacc", tx[0], 64'd20_000_000);
    reset = 0;
    #1;
    chk("abort_tacc", tx[0], 64'd0);
    chk("abort_ttot", tx[3], 64'd0);
    chk("abort_finish", 64'(finish), 64'd0);
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    launch();
    chk("restart_tconst", tx[1], 64'd16_000_000);
    chk("restart_ttot", tx[3], 64'd56_000_000);
    release_start();
    chk("retain_ttot", tx[3], 64'd56_000_000);
    set_axis(0, 100, 1000, 2000, 10000, 80);
    start = 1;
    repeat (50) @(posedge clk);
    #1;
    start = 0;
    repeat (700) @(posedge clk);
    #1;
    chk("drop_busy_finish", 64'(finish), 64'd0);
    chk("drop_busy_tacc", tx[0], 64'd5_000_000);
    chk("drop_busy_ttot", tx[3], 64'd10_000_000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
